quad_enc_ctrl: RTL

Parametrised rotary-encoder controller for the Pmod encoder demo. It synchronises and debounces the quadrature pair A/B and the push button, then decodes direction. Detents accumulate into a wrap-or-saturate position counter, and the low nibble drives a registered 7-segment display. The button toggles a hold mode that freezes the counter, and illegal quadrature transitions are flagged.

---
 rtl/enc_pkg.sv | 35 +++
 rtl/enc_input_filter.sv | 35 +++
 rtl/quad_enc_ctrl.sv | 85 ++++++++
 3 files changed

// File: rtl/enc_pkg.sv
// enc_pkg: quadrature state constants, hex-to-7-segment lookup and FSM state type
package enc_pkg;
  localparam logic [1:0] Q00 = 2'b00;
  localparam logic [1:0] Q01 = 2'b01;
  localparam logic [1:0] Q11 = 2'b11;
  localparam logic [1:0] Q10 = 2'b10;
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  // Next {A,B} in the clockwise sequence 00->01->11->10->00
  function automatic logic [1:0] quad_next(input logic [1:0] s);
    return s == Q00 ? Q01 : s == Q01 ? Q11 : s == Q11 ? Q10 : Q00;
  endfunction
  // Active-high {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction
endpackage

// File: rtl/enc_input_filter.sv
// enc_input_filter: 2-flop synchroniser plus FILT_CYCLES-stable debounce
//   clk, rst_n : clock, synchronous active-low reset
//   i_d        : asynchronous raw input
//   i_load     : copy the synchronised value straight to the output
//   o_q        : filtered output
module enc_input_filter #(
  parameter int FILT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  input  logic i_load,
  output logic o_q
);
  logic [1:0] r_sync;
  logic [7:0] r_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_cnt  <= '0;
      o_q    <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_d};
      if (i_load || r_sync[1] == o_q) begin
        o_q   <= i_load ? r_sync[1] : o_q;
        r_cnt <= '0;
      end else if (r_cnt == 8'(FILT_CYCLES - 1)) begin
        o_q   <= r_sync[1];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end
endmodule

// File: rtl/quad_enc_ctrl.sv
// quad_enc_ctrl: debounced quadrature decoder with position counter, hold mode and 7-seg output
//   clk, rst_n            : clock, synchronous active-low reset
//   ena                   : enable for counting and button actions
//   enc_a, enc_b, enc_btn : asynchronous encoder pins
//   count, step, dir, err : position, detent pulse, last direction, illegal-transition pulse
//   hold, seg             : hold mode (LED), registered hex digit of count[3:0]
module quad_enc_ctrl
  import enc_pkg::*;
#(
  parameter int CNT_W       = 4,
  parameter int FILT_CYCLES = 4,
  parameter int DETENT_DIV  = 4,
  parameter int SAT         = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             enc_btn,
  output logic [CNT_W-1:0] count,
  output logic             step,
  output logic             dir,
  output logic             err,
  output logic             hold,
  output logic [6:0]       seg
);
  localparam logic signed [3:0] DIV = 4'(DETENT_DIV);
  state_t            r_state;
  logic [8:0]        r_init_cnt;
  logic [1:0]        r_prev_ab;
  logic              r_prev_btn;
  logic signed [3:0] r_acc;
  logic              w_a, w_b, w_btn, w_load, w_act, w_cw, w_ccw, w_bad, w_up, w_dn, w_step, w_tog;
  logic [1:0]        w_ab;
  logic signed [3:0] w_acc_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  assign w_load = r_state == ST_INIT;
  enc_input_filter #(.FILT_CYCLES(FILT_CYCLES)) u_fa   (.clk(clk), .rst_n(rst_n), .i_d(enc_a),   .i_load(w_load), .o_q(w_a));
  enc_input_filter #(.FILT_CYCLES(FILT_CYCLES)) u_fb   (.clk(clk), .rst_n(rst_n), .i_d(enc_b),   .i_load(w_load), .o_q(w_b));
  enc_input_filter #(.FILT_CYCLES(FILT_CYCLES)) u_fbtn (.clk(clk), .rst_n(rst_n), .i_d(enc_btn), .i_load(w_load), .o_q(w_btn));
  assign w_ab      = {w_a, w_b};
  assign w_act     = r_state == ST_RUN && ena;
  assign w_cw      = w_ab == quad_next(r_prev_ab);
  assign w_ccw     = r_prev_ab == quad_next(w_ab);
  assign w_bad     = (w_ab ^ r_prev_ab) == 2'b11;
  assign w_acc_nxt = r_acc + (w_cw ? 4'sd1 : w_ccw ? -4'sd1 : 4'sd0);
  assign w_up      = w_acc_nxt == DIV;
  assign w_dn      = w_acc_nxt == -DIV;
  assign w_step    = w_act && (w_up || w_dn);
  assign w_tog     = w_act && w_btn && !r_prev_btn;
  assign w_cnt_nxt = w_up ? ((SAT != 0 && count == '1) ? count : count + 1'b1)
                          : ((SAT != 0 && count == '0) ? count : count - 1'b1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
      r_prev_ab  <= Q00;
      r_prev_btn <= 1'b0;
      r_acc      <= '0;
      count      <= '0;
      step       <= 1'b0;
      dir        <= 1'b0;
      err        <= 1'b0;
      hold       <= 1'b0;
      seg        <= 7'b0111111;
    end else begin
      r_prev_ab  <= w_ab;
      r_prev_btn <= w_btn;
      // Accumulator is forced to 0 while disabled so re-enable starts a fresh detent
      r_acc      <= (!w_act || w_up || w_dn) ? 4'sd0 : w_acc_nxt;
      step       <= w_step;
      err        <= w_act && w_bad;
      if (w_step) dir <= w_up;
      // Uses the pre-toggle hold when a step and a button edge coincide
      if (w_step && !hold) count <= w_cnt_nxt;
      if (w_tog) hold <= !hold;
      seg <= hex_to_seg(count[3:0]);
      if (r_state == ST_INIT) begin
        r_init_cnt <= r_init_cnt + 9'd1;
        if (r_init_cnt == 9'(FILT_CYCLES + 1)) r_state <= ST_RUN;
      end
    end
  end
endmodule
